// File: rtl/dm_pkg.sv
// Shared types for the MEM-stage data-memory responder: FSM states and the
// encodings of the DM_size / DM_rfw request fields.
package dm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dm_state_e;

   localparam logic DM_BYTE  = 1'b0;
   localparam logic DM_WORD  = 1'b1;
   localparam logic DM_READ  = 1'b0;
   localparam logic DM_WRITE = 1'b1;

   // Wide enough for WAIT_STATES up to 15.
   localparam int DM_CNT_W = 4;

   function automatic logic dm_misaligned(input logic size, input logic [1:0] lsb);
      return (size == DM_WORD) && (lsb != 2'b00);
   endfunction

endpackage

// File: rtl/dm_byte_ram.sv
// Byte-addressed big-endian storage: synchronous write, combinational read.
// Word accesses are aligned down to a 4-byte boundary; byte reads zero-extend.
module dm_byte_ram
   import dm_pkg::*;
#(
   parameter int ADDR_BITS = 8
) (
   input  logic                 clk,
   input  logic                 we_i,
   input  logic                 size_i,
   input  logic [ADDR_BITS-1:0] addr_i,
   input  logic [31:0]          wdata_i,
   output logic [31:0]          rdata_o
);

   localparam int DEPTH = 2**ADDR_BITS;

   logic [7:0] Mem [0:DEPTH-1];

   logic [ADDR_BITS-1:0] a0;
   logic [ADDR_BITS-1:0] a1;
   logic [ADDR_BITS-1:0] a2;
   logic [ADDR_BITS-1:0] a3;

   always_comb begin
      a0 = addr_i;
      if (size_i == DM_WORD) begin
         a0[1:0] = 2'b00;
      end
      a1 = a0 + ADDR_BITS'(1);
      a2 = a0 + ADDR_BITS'(2);
      a3 = a0 + ADDR_BITS'(3);
   end

   always_comb begin
      if (size_i == DM_WORD) begin
         rdata_o = {Mem[a0], Mem[a1], Mem[a2], Mem[a3]};
      end else begin
         rdata_o = {24'h0, Mem[a0]};
      end
   end

   // Most significant byte lives at the lowest address.
   always_ff @(posedge clk) begin
      if (we_i) begin
         if (size_i == DM_WORD) begin
            Mem[a0] <= wdata_i[31:24];
            Mem[a1] <= wdata_i[23:16];
            Mem[a2] <= wdata_i[15:8];
            Mem[a3] <= wdata_i[7:0];
         end else begin
            Mem[a0] <= wdata_i[7:0];
         end
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side end of the EX_MEM DM_enable/DM_rfw/DM_size protocol: sequences
// each access through a programmable wait period and stalls the pipeline.
//
// state | meaning
// IDLE  | no access in flight; an enabled request is latched here
// WAIT  | counting down wait states; dropping enable aborts the access
// RESP  | access committed on the entering edge; dm_done high this cycle
module data_mem_responder
   import dm_pkg::*;
#(
   parameter int ADDR_BITS   = 8,
   parameter int WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MEM_DM_enable,
   input  logic        MEM_DM_rfw,
   input  logic        MEM_DM_size,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic [31:0] dm_rdata,
   output logic        dm_stall,
   output logic        dm_done,
   output logic        dm_align_err
);

   localparam logic                NO_WAIT = (WAIT_STATES == 0);
   localparam logic [DM_CNT_W-1:0] WS_LOAD = DM_CNT_W'(WAIT_STATES);

   dm_state_e            state_q;
   logic [DM_CNT_W-1:0]  cnt_q;
   logic                 rfw_q;
   logic                 size_q;
   logic [ADDR_BITS-1:0] addr_q;
   logic [31:0]          wdata_q;
   logic [31:0]          rdata_q;
   logic                 done_q;
   logic                 align_q;

   logic                 rfw_d;
   logic                 size_d;
   logic [ADDR_BITS-1:0] addr_d;
   logic [31:0]          wdata_d;
   logic                 enter_resp;
   logic                 ram_we;
   logic [31:0]          ram_rdata;
   logic                 unused_addr_hi;

   assign unused_addr_hi = ^dm_addr[31:ADDR_BITS];

   // With no wait states the commit edge is the request edge itself, so the
   // live request fields feed the RAM instead of the latched copies.
   always_comb begin
      rfw_d      = rfw_q;
      size_d     = size_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      enter_resp = 1'b0;
      case (state_q)
         IDLE: begin
            rfw_d      = MEM_DM_rfw;
            size_d     = MEM_DM_size;
            addr_d     = dm_addr[ADDR_BITS-1:0];
            wdata_d    = dm_wdata;
            enter_resp = MEM_DM_enable && NO_WAIT;
         end
         WAIT: begin
            enter_resp = MEM_DM_enable && (cnt_q == DM_CNT_W'(1));
         end
         default: begin
            enter_resp = 1'b0;
         end
      endcase
   end

   // Gating with reset keeps a write from landing on an edge where reset is held.
   assign ram_we = enter_resp && (rfw_d == DM_WRITE) && reset;

   dm_byte_ram #(
      .ADDR_BITS (ADDR_BITS)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .size_i  (size_d),
      .addr_i  (addr_d),
      .wdata_i (wdata_d),
      .rdata_o (ram_rdata)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rfw_q   <= DM_READ;
         size_q  <= DM_BYTE;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         done_q  <= 1'b0;
         align_q <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         align_q <= 1'b0;
         if (enter_resp) begin
            done_q  <= 1'b1;
            align_q <= dm_misaligned(size_d, addr_d[1:0]);
            if (rfw_d == DM_READ) begin
               rdata_q <= ram_rdata;
            end
         end
         case (state_q)
            IDLE: begin
               if (MEM_DM_enable) begin
                  rfw_q   <= rfw_d;
                  size_q  <= size_d;
                  addr_q  <= addr_d;
                  wdata_q <= wdata_d;
                  cnt_q   <= WS_LOAD;
                  state_q <= NO_WAIT ? RESP : WAIT;
               end
            end
            WAIT: begin
               if (!MEM_DM_enable) begin
                  state_q <= IDLE;
               end else if (cnt_q == DM_CNT_W'(1)) begin
                  state_q <= RESP;
               end else begin
                  cnt_q <= cnt_q - DM_CNT_W'(1);
               end
            end
            RESP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign dm_stall     = MEM_DM_enable && (state_q != RESP);
   assign dm_rdata     = rdata_q;
   assign dm_done      = done_q;
   assign dm_align_err = align_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (2 wait states and 0 wait states)
// driven by a directed vector table, randomized accesses and reset sequences.
module tb_data_mem_responder;
   import dm_pkg::*;

   localparam int WS_A = 2;
   localparam int WS_B = 0;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        en    [2];
   logic        rfw   [2];
   logic        sz    [2];
   logic [31:0] addr  [2];
   logic [31:0] wdata [2];

   logic [31:0] rdata_w0, rdata_w1;
   logic        stall_w0, stall_w1, done_w0, done_w1, al_w0, al_w1;

   data_mem_responder #(.ADDR_BITS(8), .WAIT_STATES(WS_A)) u_ws2 (
      .clk(clk), .reset(reset), .MEM_DM_enable(en[0]), .MEM_DM_rfw(rfw[0]),
      .MEM_DM_size(sz[0]), .dm_addr(addr[0]), .dm_wdata(wdata[0]),
      .dm_rdata(rdata_w0), .dm_stall(stall_w0), .dm_done(done_w0), .dm_align_err(al_w0));

   data_mem_responder #(.ADDR_BITS(8), .WAIT_STATES(WS_B)) u_ws0 (
      .clk(clk), .reset(reset), .MEM_DM_enable(en[1]), .MEM_DM_rfw(rfw[1]),
      .MEM_DM_size(sz[1]), .dm_addr(addr[1]), .dm_wdata(wdata[1]),
      .dm_rdata(rdata_w1), .dm_stall(stall_w1), .dm_done(done_w1), .dm_align_err(al_w1));

   int ws_of [2];
   int vectors = 0;
   int miscompares = 0;

   // Reference model: plain byte arrays plus the last value returned by a read.
   logic [7:0]  mm  [2][256];
   logic [31:0] mrd [2];

   typedef struct {
      int          u;
      logic        r;
      logic        s;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] exp_rd;
      logic        exp_al;
   } vec_t;
   vec_t tbl[$];

   function automatic void add_vec(input int u, input logic r, input logic s, input logic [31:0] a,
                                   input logic [31:0] d, input logic [31:0] er, input logic ea);
      vec_t v;
      v.u = u; v.r = r; v.s = s; v.a = a; v.d = d; v.exp_rd = er; v.exp_al = ea;
      tbl.push_back(v);
   endfunction

   function automatic logic [31:0] rd_of(input int u);
      return (u == 0) ? rdata_w0 : rdata_w1;
   endfunction
   function automatic logic stall_of(input int u);
      return (u == 0) ? stall_w0 : stall_w1;
   endfunction
   function automatic logic done_of(input int u);
      return (u == 0) ? done_w0 : done_w1;
   endfunction
   function automatic logic al_of(input int u);
      return (u == 0) ? al_w0 : al_w1;
   endfunction

   function automatic void model_access(input int u, input logic r, input logic s, input logic [31:0] a,
                                        input logic [31:0] d, output logic [31:0] rd, output logic al);
      int base;
      base = int'(a % 256);
      al = (s == DM_WORD) && ((a % 4) != 0);
      if (s == DM_WORD) base = base - (base % 4);
      if (r == DM_WRITE) begin
         if (s == DM_WORD) begin
            for (int k = 0; k < 4; k++) mm[u][base + k] = d[31 - 8*k -: 8];
         end else begin
            mm[u][base] = d[7:0];
         end
      end else begin
         if (s == DM_WORD)
            mrd[u] = {mm[u][base], mm[u][base + 1], mm[u][base + 2], mm[u][base + 3]};
         else
            mrd[u] = {24'h0, mm[u][base]};
      end
      rd = mrd[u];
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic drive_junk(input int u);
      rfw[u]   = 1'($urandom);
      sz[u]    = 1'($urandom);
      addr[u]  = $urandom;
      wdata[u] = $urandom;
   endtask

   // Starts just after a negedge; holds the request until RESP, ends at a negedge.
   task automatic run_access(input int u, input logic r, input logic s, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_al,
                             input logic [31:0] prev_rd);
      int stalls;
      int early;
      int held;
      stalls = 0; early = 0; held = 1;
      for (int c = 0; c <= ws_of[u]; c++) begin
         en[u] = 1'b1;
         if (c == 0) begin
            rfw[u] = r; sz[u] = s; addr[u] = a; wdata[u] = d;
         end else begin
            drive_junk(u);
         end
         #1;
         if (stall_of(u)) stalls++;
         if (done_of(u)) early++;
         if (rd_of(u) !== prev_rd) held = 0;
         @(negedge clk);
      end
      check("stall_cycles", 32'(stalls), 32'(ws_of[u] + 1));
      check("early_done", 32'(early), 32'd0);
      check("rdata_hold", 32'(held), 32'd1);
      en[u] = 1'b1;
      drive_junk(u);
      #1;
      check("done", 32'(done_of(u)), 32'd1);
      check("stall_resp", 32'(stall_of(u)), 32'd0);
      check("align_err", 32'(al_of(u)), 32'(exp_al));
      check("rdata", rd_of(u), exp_rd);
      @(negedge clk);
      en[u] = 1'b0;
   endtask

   task automatic run_abort(input int u, input logic r, input logic s, input logic [31:0] a,
                            input logic [31:0] d, input int k);
      int stalls;
      int early;
      stalls = 0; early = 0;
      for (int c = 0; c < k; c++) begin
         en[u] = 1'b1;
         if (c == 0) begin
            rfw[u] = r; sz[u] = s; addr[u] = a; wdata[u] = d;
         end else begin
            drive_junk(u);
         end
         #1;
         if (stall_of(u)) stalls++;
         if (done_of(u)) early++;
         @(negedge clk);
      end
      en[u] = 1'b0;
      drive_junk(u);
      #1;
      if (done_of(u)) early++;
      check("abort_stall_cycles", 32'(stalls), 32'(k));
      check("abort_stall_low", 32'(stall_of(u)), 32'd0);
      @(negedge clk);
      #1;
      if (done_of(u)) early++;
      check("abort_no_done", 32'(early), 32'd0);
      check("abort_rdata", rd_of(u), mrd[u]);
      @(negedge clk);
   endtask

   task automatic idle_cycle(input int u);
      en[u] = 1'b0;
      drive_junk(u);
      #1;
      check("idle_stall", 32'(stall_of(u)), 32'd0);
      check("idle_done", 32'(done_of(u)), 32'd0);
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      int          u;
      int          pick;
      logic        r;
      logic        s;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] erd;
      logic [31:0] prev;
      logic        eal;
      logic [7:0]  b;
      logic [31:0] last [2];

      ws_of[0] = WS_A;
      ws_of[1] = WS_B;
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         en[i] = 1'b0; rfw[i] = 1'b0; sz[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
         mrd[i] = '0;
      end
      for (int i = 0; i < 256; i++) begin
         b = 8'($urandom);
         u_ws2.u_ram.Mem[i] = b;
         u_ws0.u_ram.Mem[i] = b;
         mm[0][i] = b;
         mm[1][i] = b;
      end

      // Reset values, and stall following enable while held in reset.
      @(negedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         check("rst_rdata", rd_of(i), 32'h0);
         check("rst_done", 32'(done_of(i)), 32'd0);
         check("rst_align", 32'(al_of(i)), 32'd0);
         check("rst_stall", 32'(stall_of(i)), 32'd0);
      end
      en[0] = 1'b1;
      #1;
      check("rst_stall_en", 32'(stall_of(0)), 32'd1);
      en[0] = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Directed table, applied back-to-back.
      add_vec(0, DM_WRITE, DM_WORD, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0);
      add_vec(0, DM_READ,  DM_WORD, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0);
      add_vec(0, DM_READ,  DM_BYTE, 32'h11,  32'h0,        32'h000000AD, 1'b0);
      add_vec(0, DM_WRITE, DM_BYTE, 32'h12,  32'hFFFFFF55, 32'h000000AD, 1'b0);
      add_vec(0, DM_READ,  DM_WORD, 32'h10,  32'h0,        32'hDEAD55EF, 1'b0);
      add_vec(0, DM_READ,  DM_WORD, 32'h13,  32'h0,        32'hDEAD55EF, 1'b1);
      add_vec(0, DM_WRITE, DM_WORD, 32'hFC,  32'hCAFEF00D, 32'hDEAD55EF, 1'b0);
      add_vec(0, DM_READ,  DM_WORD, 32'hFE,  32'h0,        32'hCAFEF00D, 1'b1);
      add_vec(0, DM_READ,  DM_BYTE, 32'hFF,  32'h0,        32'h0000000D, 1'b0);
      add_vec(0, DM_WRITE, DM_WORD, 32'h103, 32'h01020304, 32'h0000000D, 1'b1);
      add_vec(0, DM_READ,  DM_WORD, 32'h0,   32'h0,        32'h01020304, 1'b0);
      add_vec(0, DM_READ,  DM_BYTE, 32'h202, 32'h0,        32'h00000003, 1'b0);
      add_vec(1, DM_WRITE, DM_WORD, 32'h80,  32'hA1B2C3D4, 32'h0,        1'b0);
      add_vec(1, DM_READ,  DM_BYTE, 32'h83,  32'h0,        32'h000000D4, 1'b0);
      add_vec(1, DM_READ,  DM_WORD, 32'h81,  32'h0,        32'hA1B2C3D4, 1'b1);
      add_vec(1, DM_WRITE, DM_BYTE, 32'h81,  32'h00000077, 32'hA1B2C3D4, 1'b0);
      add_vec(1, DM_READ,  DM_WORD, 32'h80,  32'h0,        32'hA177C3D4, 1'b0);

      last[0] = '0;
      last[1] = '0;
      foreach (tbl[i]) begin
         model_access(tbl[i].u, tbl[i].r, tbl[i].s, tbl[i].a, tbl[i].d, erd, eal);
         run_access(tbl[i].u, tbl[i].r, tbl[i].s, tbl[i].a, tbl[i].d,
                    tbl[i].exp_rd, tbl[i].exp_al, last[tbl[i].u]);
         last[tbl[i].u] = tbl[i].exp_rd;
      end
      idle_cycle(0);
      check("mem_10", {u_ws2.u_ram.Mem[8'h10], u_ws2.u_ram.Mem[8'h11],
                       u_ws2.u_ram.Mem[8'h12], u_ws2.u_ram.Mem[8'h13]}, 32'hDEAD55EF);
      check("mem_fc", {u_ws2.u_ram.Mem[8'hFC], u_ws2.u_ram.Mem[8'hFD],
                       u_ws2.u_ram.Mem[8'hFE], u_ws2.u_ram.Mem[8'hFF]}, 32'hCAFEF00D);
      check("mem_00_wrap", {u_ws2.u_ram.Mem[8'h00], u_ws2.u_ram.Mem[8'h01],
                            u_ws2.u_ram.Mem[8'h02], u_ws2.u_ram.Mem[8'h03]}, 32'h01020304);

      // Randomized accesses, aborts and idle gaps against the model.
      for (int n = 0; n < 250; n++) begin
         u    = int'($urandom_range(1, 0));
         pick = int'($urandom_range(9, 0));
         r    = 1'($urandom);
         s    = 1'($urandom);
         a    = $urandom;
         if ($urandom_range(3, 0) != 0) a[7:0] = 8'($urandom_range(63, 0));
         d    = $urandom;
         if (pick == 0) begin
            idle_cycle(u);
         end else if (pick <= 2 && ws_of[u] > 0) begin
            run_abort(u, r, s, a, d, int'($urandom_range(ws_of[u], 1)));
         end else begin
            prev = mrd[u];
            model_access(u, r, s, a, d, erd, eal);
            run_access(u, r, s, a, d, erd, eal, prev);
         end
      end

      // Reset pulsed in the WAIT cycle of a word write.
      en[0] = 1'b1; rfw[0] = DM_WRITE; sz[0] = DM_WORD; addr[0] = 32'h20; wdata[0] = 32'h12345678;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("wait_rst_rdata", rd_of(0), 32'h0);
      check("wait_rst_done", 32'(done_of(0)), 32'd0);
      check("wait_rst_stall_en", 32'(stall_of(0)), 32'd1);
      check("wait_rst_state", 32'(u_ws2.state_q), 32'(IDLE));
      en[0] = 1'b0;
      #1;
      check("wait_rst_stall_low", 32'(stall_of(0)), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      mrd[0] = '0;
      mrd[1] = '0;
      check("wait_rst_rdata_b", rd_of(1), 32'h0);
      for (int i = 0; i < 4; i++) idle_cycle(0);
      for (int k = 0; k < 4; k++)
         check("wait_rst_mem", 32'(u_ws2.u_ram.Mem[8'h20 + k]), 32'(mm[0][8'h20 + k]));

      // Reset held across the edge that would enter RESP (2 wait states).
      en[0] = 1'b1; rfw[0] = DM_WRITE; sz[0] = DM_WORD; addr[0] = 32'h30;
      wdata[0] = ~{mm[0][8'h30], mm[0][8'h31], mm[0][8'h32], mm[0][8'h33]};
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      en[0] = 1'b0;
      #1;
      reset = 1'b1;
      check("resp_rst_done_a", 32'(done_of(0)), 32'd0);
      @(negedge clk);
      for (int i = 0; i < 3; i++) idle_cycle(0);
      for (int k = 0; k < 4; k++)
         check("resp_rst_mem_a", 32'(u_ws2.u_ram.Mem[8'h30 + k]), 32'(mm[0][8'h30 + k]));

      // Same for zero wait states: the request edge is the commit edge.
      en[1] = 1'b1; rfw[1] = DM_WRITE; sz[1] = DM_BYTE; addr[1] = 32'h40;
      wdata[1] = {24'h0, ~mm[1][8'h40]};
      #1;
      reset = 1'b0;
      @(negedge clk);
      en[1] = 1'b0;
      #1;
      check("resp_rst_done_b", 32'(done_of(1)), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 2; i++) idle_cycle(1);
      check("resp_rst_mem_b", 32'(u_ws0.u_ram.Mem[8'h40]), 32'(mm[1][8'h40]));

      // Recovery after reset on both instances.
      for (int i = 0; i < 2; i++) begin
         prev = mrd[i];
         model_access(i, DM_READ, DM_WORD, 32'h20, 32'h0, erd, eal);
         run_access(i, DM_READ, DM_WORD, 32'h20, 32'h0, erd, eal, prev);
         prev = mrd[i];
         model_access(i, DM_READ, DM_WORD, 32'h30, 32'h0, erd, eal);
         run_access(i, DM_READ, DM_WORD, 32'h30, 32'h0, erd, eal, prev);
      end
      idle_cycle(0);
      idle_cycle(1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
